// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, DMA and memory-bus signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic        c_req;
  logic [31:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        c_err;
  logic        core_stall;

  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_req;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  // arbiter side
  modport slave (
    input  c_req, c_addr, c_be, c_wdata,
    input  d_req, d_addr, d_be, d_wdata,
    input  m_ack, m_rdata,
    output c_gnt, c_rvalid, c_rdata, c_err, core_stall,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_req, m_addr, m_we, m_be, m_wdata
  );

  // requesters and memory side
  modport master (
    output c_req, c_addr, c_be, c_wdata,
    output d_req, d_addr, d_be, d_wdata,
    output m_ack, m_rdata,
    input  c_gnt, c_rvalid, c_rdata, c_err, core_stall,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_req, m_addr, m_we, m_be, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/DMA arbiter and sequencer for the data-memory bus
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;
  localparam int   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          last_owner;
  logic [CW-1:0] cnt;
  logic          c_win;
  logic          d_win;
  logic          grant;
  logic          timed_out;
  logic          done;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  assign timed_out  = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) == TIMEOUT);
  assign done       = bus.m_ack || timed_out;
  assign resp_rdata = (bus.m_ack && !bus.m_we) ? bus.m_rdata : 32'd0;
  assign resp_err   = ~bus.m_ack;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUS;
      BUS:     if (done)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // on a tie the requester that did not own the previous transaction wins
  always_comb begin
    c_win          = 1'b0;
    d_win          = 1'b0;
    if (rstn && state == IDLE) begin
      c_win = bus.c_req & (~bus.d_req | last_owner);
      d_win = bus.d_req & (~bus.c_req | ~last_owner);
    end
    grant          = c_win | d_win;
    bus.c_gnt      = c_win;
    bus.d_gnt      = d_win;
    bus.core_stall = rstn & ((bus.c_req & ~c_win) | (state == BUS && owner == OWN_CORE));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.m_req    <= 1'b0;
      bus.m_addr   <= 32'd0;
      bus.m_we     <= 1'b0;
      bus.m_be     <= 4'd0;
      bus.m_wdata  <= 32'd0;
      bus.c_rvalid <= 1'b0;
      bus.c_rdata  <= 32'd0;
      bus.c_err    <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= 32'd0;
      bus.d_err    <= 1'b0;
      owner        <= OWN_CORE;
      last_owner   <= OWN_DMA;
      cnt          <= '0;
    end else begin
      bus.c_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner       <= d_win;
            cnt         <= '0;
            bus.m_req   <= 1'b1;
            bus.m_addr  <= d_win ? bus.d_addr  : bus.c_addr;
            bus.m_be    <= d_win ? bus.d_be    : bus.c_be;
            bus.m_we    <= d_win ? |bus.d_be   : |bus.c_be;
            bus.m_wdata <= d_win ? bus.d_wdata : bus.c_wdata;
          end
        end
        BUS: begin
          if (done) begin
            bus.m_req <= 1'b0;
            if (owner == OWN_DMA) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= resp_rdata;
              bus.d_err    <= resp_err;
            end else begin
              bus.c_rvalid <= 1'b1;
              bus.c_rdata  <= resp_rdata;
              bus.c_err    <= resp_err;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: last_owner <= owner;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int TMO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        who;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          n_bus;
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vt[7];
  int   total  = 0;
  int   bad    = 0;
  int   n_resp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic push(input logic who, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.who   = who;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // sample mid-cycle; any completion pulse is matched against the scoreboard
  task automatic sample();
    rsp_t e;
    @(negedge clk);
    if (bus.c_rvalid || bus.d_rvalid) begin
      n_resp++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got c_rvalid=%b d_rvalid=%b want none", bus.c_rvalid, bus.d_rvalid);
      end else begin
        e = sb.pop_front();
        chk1("rsp_who", bus.d_rvalid, e.who);
        chk1("rsp_excl", bus.c_rvalid & bus.d_rvalid, 1'b0);
        chk("rsp_rdata", e.who ? bus.d_rdata : bus.c_rdata, e.rdata);
        chk1("rsp_err", e.who ? bus.d_err : bus.c_err, e.err);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    int r0;
    nb = (v.n_bus == 0) ? TMO : v.n_bus;
    if (v.who) begin
      bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_be = v.be; bus.d_wdata = v.wdata;
    end else begin
      bus.c_req = 1'b1; bus.c_addr = v.addr; bus.c_be = v.be; bus.c_wdata = v.wdata;
    end
    sample();
    chk1("gnt_c", bus.c_gnt, ~v.who);
    chk1("gnt_d", bus.d_gnt, v.who);
    chk1("stall_gnt", bus.core_stall, 1'b0);
    push(v.who, v.exp_rdata, v.exp_err);
    advance();
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    bus.c_addr = ~v.addr; bus.d_addr = ~v.addr;
    bus.c_be = ~v.be; bus.d_be = ~v.be;
    bus.c_wdata = ~v.wdata; bus.d_wdata = ~v.wdata;
    for (int i = 0; i < nb; i++) begin
      if (v.n_bus != 0 && i == nb - 1) begin
        bus.m_ack = 1'b1;
        bus.m_rdata = v.mrdata;
      end
      sample();
      chk1("m_req_bus", bus.m_req, 1'b1);
      chk("m_addr", bus.m_addr, v.addr);
      chk("m_be", 32'(bus.m_be), 32'(v.be));
      chk1("m_we", bus.m_we, |v.be);
      chk("m_wdata", bus.m_wdata, v.wdata);
      chk1("stall_bus", bus.core_stall, ~v.who);
      advance();
      bus.m_ack = 1'b0;
      bus.m_rdata = 32'hBAD0_BAD0;
    end
    r0 = n_resp;
    sample();
    chk1("resp_seen", n_resp == r0 + 1, 1'b1);
    chk1("m_req_resp", bus.m_req, 1'b0);
    chk1("stall_resp", bus.core_stall, 1'b0);
    advance();
  endtask

  initial begin
    vt[0] = '{1'b0, 32'h0000_0100, 4'h0, 32'h0000_0000, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1'b0, 32'h0000_0204, 4'hC, 32'hAB12_0000, 3, 32'h5555_5555, 32'h0000_0000, 1'b0};
    vt[2] = '{1'b1, 32'h0000_3000, 4'h0, 32'h0000_0000, 2, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vt[3] = '{1'b1, 32'h0000_3004, 4'h3, 32'h0000_BEEF, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vt[4] = '{1'b0, 32'h0000_0108, 4'h0, 32'h0000_0000, 4, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
    vt[5] = '{1'b0, 32'h0000_010C, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[6] = '{1'b1, 32'h0000_3008, 4'h0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000, 1'b1};

    bus.c_req = 1'b1; bus.c_addr = 32'h100; bus.c_be = 4'h0; bus.c_wdata = 32'd0;
    bus.d_req = 1'b0; bus.d_addr = 32'd0;   bus.d_be = 4'h0; bus.d_wdata = 32'd0;
    bus.m_ack = 1'b0; bus.m_rdata = 32'd0;

    // reset state, with a core request held to show grant/stall forced low
    advance();
    advance();
    sample();
    chk1("rst_m_req", bus.m_req, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk1("rst_m_we", bus.m_we, 1'b0);
    chk("rst_m_be", 32'(bus.m_be), 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk1("rst_c_rvalid", bus.c_rvalid, 1'b0);
    chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_c_rdata", bus.c_rdata, 32'd0);
    chk1("rst_c_err", bus.c_err, 1'b0);
    chk1("rst_c_gnt", bus.c_gnt, 1'b0);
    chk1("rst_stall", bus.core_stall, 1'b0);
    advance();
    rstn = 1'b1;
    bus.c_req = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i]);
      if (vt[i].n_bus == 0) begin
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'hFFFF_0000;
        sample();
        chk1("late_ack_m_req", bus.m_req, 1'b0);
        advance();
        bus.m_ack = 1'b0;
        sample();
        chk1("late_ack_m_req2", bus.m_req, 1'b0);
        chk1("late_ack_c_rvalid", bus.c_rvalid, 1'b0);
        chk1("late_ack_d_rvalid", bus.d_rvalid, 1'b0);
        advance();
      end
    end

    // reset for one edge during BUS aborts silently
    bus.d_req = 1'b1; bus.d_addr = 32'h4000; bus.d_be = 4'h0;
    sample();
    chk1("abort_d_gnt", bus.d_gnt, 1'b1);
    advance();
    bus.d_req = 1'b0;
    sample();
    chk1("abort_m_req_bus", bus.m_req, 1'b1);
    advance();
    rstn = 1'b0;
    bus.c_req = 1'b1;
    sample();
    chk1("abort_c_gnt_forced", bus.c_gnt, 1'b0);
    chk1("abort_stall_forced", bus.core_stall, 1'b0);
    advance();
    rstn = 1'b1;
    bus.c_req = 1'b0;
    sample();
    chk1("abort_m_req", bus.m_req, 1'b0);
    chk("abort_m_addr", bus.m_addr, 32'd0);
    chk1("abort_d_rvalid", bus.d_rvalid, 1'b0);
    chk1("abort_c_rvalid", bus.c_rvalid, 1'b0);
    advance();
    run_vec('{1'b1, 32'h0000_4010, 4'h0, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0});

    // both requesting continuously: owners alternate starting with the core
    rstn = 1'b0;
    advance();
    rstn = 1'b1;
    bus.c_req = 1'b1; bus.c_addr = 32'hC0; bus.c_be = 4'h0;
    bus.d_req = 1'b1; bus.d_addr = 32'hD0; bus.d_be = 4'h0;
    for (int k = 0; k < 4; k++) begin
      logic ew;
      int   r0;
      ew = (k % 2) == 1;
      sample();
      chk1("rr_c_gnt", bus.c_gnt, ~ew);
      chk1("rr_d_gnt", bus.d_gnt, ew);
      push(ew, 32'h1000 + 32'(k), 1'b0);
      advance();
      bus.m_ack = 1'b1;
      bus.m_rdata = 32'h1000 + 32'(k);
      sample();
      chk("rr_m_addr", bus.m_addr, ew ? 32'hD0 : 32'hC0);
      chk1("rr_stall", bus.core_stall, 1'b1);
      advance();
      bus.m_ack = 1'b0;
      r0 = n_resp;
      sample();
      chk1("rr_resp_seen", n_resp == r0 + 1, 1'b1);
      chk1("rr_no_gnt_resp", bus.c_gnt | bus.d_gnt, 1'b0);
      advance();
    end
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    advance();

    // core waits behind an in-flight DMA transaction
    bus.d_req = 1'b1; bus.d_addr = 32'h5000; bus.d_be = 4'h0;
    sample();
    chk1("dma_first_gnt", bus.d_gnt, 1'b1);
    push(1'b1, 32'h77, 1'b0);
    advance();
    bus.d_req = 1'b0;
    bus.c_req = 1'b1; bus.c_addr = 32'h600; bus.c_be = 4'h0;
    sample();
    chk1("wait_stall_bus1", bus.core_stall, 1'b1);
    advance();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h77;
    sample();
    chk1("wait_stall_bus2", bus.core_stall, 1'b1);
    advance();
    bus.m_ack = 1'b0;
    sample();
    chk1("wait_stall_resp", bus.core_stall, 1'b1);
    chk1("wait_c_gnt_resp", bus.c_gnt, 1'b0);
    advance();
    sample();
    chk1("wait_c_gnt", bus.c_gnt, 1'b1);
    chk1("wait_stall_gnt", bus.core_stall, 1'b0);
    push(1'b0, 32'h88, 1'b0);
    advance();
    bus.c_req = 1'b0;
    sample();
    chk1("own_stall_bus1", bus.core_stall, 1'b1);
    advance();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h88;
    sample();
    chk1("own_stall_bus2", bus.core_stall, 1'b1);
    advance();
    bus.m_ack = 1'b0;
    sample();
    chk1("own_stall_resp", bus.core_stall, 1'b0);
    advance();
    sample();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
